// File: rtl/dmem_access.sv
// MEM-stage data-memory access unit: issues one aligned load/store per op on a
// req/ack data bus, stalls the pipeline meanwhile, and extends load results.
module dmem_access (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data,
  output logic        stallreq_mem,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 8;

  localparam logic [OP_W-1:0] OP_LB  = 8'b1110_0000;
  localparam logic [OP_W-1:0] OP_LH  = 8'b1110_0001;
  localparam logic [OP_W-1:0] OP_LW  = 8'b1110_0011;
  localparam logic [OP_W-1:0] OP_LBU = 8'b1110_0100;
  localparam logic [OP_W-1:0] OP_LHU = 8'b1110_0101;
  localparam logic [OP_W-1:0] OP_SB  = 8'b1110_1000;
  localparam logic [OP_W-1:0] OP_SH  = 8'b1110_1001;
  localparam logic [OP_W-1:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            ld_q, ld_d;

  logic            is_load, is_store, aligned, op_ok;
  logic [3:0]      be_iss;
  logic [XLEN-1:0] wdata_iss;

  // Sign/zero extension of the addressed lane of a returned read word.
  function automatic logic [XLEN-1:0] extract(input logic [OP_W-1:0] op,
                                               input logic [1:0] off,
                                               input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    logic [7:0]      b;
    logic [15:0]     h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'h0, b};
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'h0, h};
      default: extract = rdata;
    endcase
  endfunction

  // Operation decode, alignment check and store lane steering.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    aligned   = 1'b1;
    be_iss    = 4'b1111;
    wdata_iss = '0;
    case (mem_aluop)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        be_iss  = 4'b0001 << mem_mem_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        aligned = ~mem_mem_addr[0];
        be_iss  = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        is_load = 1'b1;
        aligned = (mem_mem_addr[1:0] == 2'b00);
      end
      OP_SB: begin
        is_store  = 1'b1;
        be_iss    = 4'b0001 << mem_mem_addr[1:0];
        wdata_iss = {4{mem_reg2[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        aligned   = ~mem_mem_addr[0];
        be_iss    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_iss = {2{mem_reg2[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        aligned   = (mem_mem_addr[1:0] == 2'b00);
        wdata_iss = mem_reg2;
      end
      default: ;
    endcase
    exc_adel = is_load & ~aligned;
    exc_ades = is_store & ~aligned;
    op_ok    = (is_load | is_store) & aligned;
  end

  // Next-state and stall logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    op_d         = op_q;
    off_d        = off_q;
    ld_d         = ld_q;
    stallreq_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_ok && !flush) begin
          stallreq_mem = 1'b1;
          state_d      = S_BUSY;
          req_d        = 1'b1;
          we_d         = is_store;
          addr_d       = {mem_mem_addr[31:2], 2'b00};
          be_d         = be_iss;
          wdata_d      = wdata_iss;
          op_d         = mem_aluop;
          off_d        = mem_mem_addr[1:0];
          ld_d         = is_load;
        end
      end
      S_BUSY: begin
        stallreq_mem = 1'b1;
        if (dbus_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (ld_q) load_data_d = extract(op_q, off_q, dbus_rdata);
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_DRAIN: begin
        // The flushed access completes silently; a younger op waits for IDLE.
        stallreq_mem = op_ok & ~flush;
        if (dbus_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      op_q        <= '0;
      off_q       <= '0;
      ld_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      op_q        <= op_d;
      off_q       <= off_d;
      ld_q        <= ld_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: expected bus requests and load results are
// queued when an op is driven and compared when the DUT produces them.
module tb_dmem_access;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic        flush;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] load_data;
  logic        stallreq_mem, exc_adel, exc_ades;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_ld_q[$];
  logic [31:0] last_ld;
  int          errors = 0;
  int          checks = 0;

  dmem_access dut (
    .cpu_clk_75M (cpu_clk_75M),
    .cpu_rst_n   (cpu_rst_n),
    .mem_aluop   (mem_aluop),
    .mem_mem_addr(mem_mem_addr),
    .mem_reg2    (mem_reg2),
    .flush       (flush),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_be     (dbus_be),
    .dbus_wdata  (dbus_wdata),
    .dbus_ack    (dbus_ack),
    .dbus_rdata  (dbus_rdata),
    .load_data   (load_data),
    .stallreq_mem(stallreq_mem),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk32(tag, 32'(obs), 32'(exp));
  endtask

  function automatic logic [3:0] be_m(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] blane;
    case (off)
      2'd0: blane = 4'b0001;
      2'd1: blane = 4'b0010;
      2'd2: blane = 4'b0100;
      default: blane = 4'b1000;
    endcase
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return blane;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (off >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wd_m(input logic [7:0] op, input logic [31:0] r);
    if (op == OP_SB) return {r[7:0], r[7:0], r[7:0], r[7:0]};
    if (op == OP_SH) return {r[15:0], r[15:0]};
    if (op == OP_SW) return r;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ld_m(input logic [7:0] op, input logic [1:0] off,
                                       input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = (off >= 2'd2) ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return 32'($signed(b));
      OP_LBU:  return 32'(b);
      OP_LH:   return 32'($signed(h));
      OP_LHU:  return 32'(h);
      default: return rd;
    endcase
  endfunction

  // One complete access from IDLE; call at a falling edge.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int ack_delay, input logic fl_at_ack);
    req_t e;
    bit   got;
    logic is_st;
    is_st        = (op == OP_SB || op == OP_SH || op == OP_SW);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = be_m(op, addr[1:0]);
    e.wdata = wd_m(op, reg2);
    e.we    = is_st;
    exp_req_q.push_back(e);
    if (!is_st) last_ld = ld_m(op, addr[1:0], rdata);
    exp_ld_q.push_back(last_ld);
    #1;
    chk1("stall_on_issue", stallreq_mem, 1'b1);
    chk1("req_before_issue", dbus_req, 1'b0);
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge cpu_clk_75M);
      got = dbus_req;
    end
    chk1("req_timeout", got, 1'b1);
    e = exp_req_q.pop_front();
    if (got) begin
      chk32("dbus_addr", dbus_addr, e.addr);
      chk32("dbus_be", 32'(dbus_be), 32'(e.be));
      chk32("dbus_wdata", dbus_wdata, e.wdata);
      chk1("dbus_we", dbus_we, e.we);
    end
    for (int i = 0; i < ack_delay; i++) begin
      chk1("stall_busy", stallreq_mem, 1'b1);
      @(negedge cpu_clk_75M);
      chk1("req_held", dbus_req, 1'b1);
      chk32("addr_held", dbus_addr, e.addr);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    flush      = fl_at_ack;
    @(negedge cpu_clk_75M);
    dbus_ack   = 1'b0;
    flush      = 1'b0;
    dbus_rdata = 32'h0;
    chk1("req_done", dbus_req, 1'b0);
    chk1("stall_done", stallreq_mem, 1'b0);
    chk32("load_data", load_data, exp_ld_q.pop_front());
    mem_aluop = OP_NOP;
    @(negedge cpu_clk_75M);
  endtask

  initial begin
    cpu_rst_n    = 1'b0;
    mem_aluop    = OP_NOP;
    mem_mem_addr = 32'h0;
    mem_reg2     = 32'h0;
    flush        = 1'b0;
    dbus_ack     = 1'b0;
    dbus_rdata   = 32'h0;
    last_ld      = 32'h0;
    #1;
    chk1("rst_req", dbus_req, 1'b0);
    chk1("rst_we", dbus_we, 1'b0);
    chk32("rst_addr", dbus_addr, 32'h0);
    chk32("rst_be", 32'(dbus_be), 32'h0);
    chk32("rst_wdata", dbus_wdata, 32'h0);
    chk32("rst_load_data", load_data, 32'h0);
    chk1("rst_stall", stallreq_mem, 1'b0);
    chk1("rst_adel", exc_adel, 1'b0);
    chk1("rst_ades", exc_ades, 1'b0);
    repeat (2) @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk_75M);

    // Loads, stores, varying ack delay, ack coinciding with flush.
    run_txn(OP_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(OP_LB,  32'h0000_0103, 32'h0, 32'h8011_2233, 1, 1'b0);
    run_txn(OP_LBU, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b0);
    run_txn(OP_LH,  32'h0000_0102, 32'h0, 32'h8011_2233, 2, 1'b1);
    run_txn(OP_SB,  32'h0000_0201, 32'h0000_00A5, 32'h1111_1111, 0, 1'b0);
    run_txn(OP_SH,  32'h0000_0202, 32'h1234_BEEF, 32'h0, 1, 1'b0);
    run_txn(OP_SW,  32'h0000_0204, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    run_txn(OP_LHU, 32'h0000_0100, 32'h0, 32'h1234_ABCD, 0, 1'b0);
    run_txn(OP_LB,  32'h0000_0101, 32'h0, 32'h0000_7F00, 0, 1'b0);

    // Misaligned accesses raise exceptions and never reach the bus.
    mem_aluop = OP_LW; mem_mem_addr = 32'h0000_0102;
    #1;
    chk1("adel_lw", exc_adel, 1'b1);
    chk1("adel_stall", stallreq_mem, 1'b0);
    repeat (2) begin
      @(negedge cpu_clk_75M);
      chk1("adel_no_req", dbus_req, 1'b0);
    end
    mem_aluop = OP_SH; mem_mem_addr = 32'h0000_0101; mem_reg2 = 32'h5555_5555;
    #1;
    chk1("ades_sh", exc_ades, 1'b1);
    chk1("ades_adel_clear", exc_adel, 1'b0);
    @(negedge cpu_clk_75M);
    chk1("ades_no_req", dbus_req, 1'b0);

    // Flush in IDLE suppresses the request.
    mem_aluop = OP_LW; mem_mem_addr = 32'h0000_0100; flush = 1'b1;
    #1;
    chk1("flush_idle_stall", stallreq_mem, 1'b0);
    @(negedge cpu_clk_75M);
    chk1("flush_idle_no_req", dbus_req, 1'b0);
    flush = 1'b0; mem_aluop = OP_NOP;
    @(negedge cpu_clk_75M);

    // Flush in BUSY drains; a younger op waits and then issues.
    mem_aluop = OP_LW; mem_mem_addr = 32'h0000_0300;
    @(negedge cpu_clk_75M);
    chk1("drain_req_issued", dbus_req, 1'b1);
    flush = 1'b1;
    @(negedge cpu_clk_75M);
    flush = 1'b0; mem_aluop = OP_NOP;
    #1;
    chk1("drain_stall_off", stallreq_mem, 1'b0);
    chk1("drain_req_held", dbus_req, 1'b1);
    @(negedge cpu_clk_75M);
    mem_aluop = OP_LBU; mem_mem_addr = 32'h0000_0401;
    #1;
    chk1("drain_new_op_stall", stallreq_mem, 1'b1);
    chk32("drain_addr_held", dbus_addr, 32'h0000_0300);
    @(negedge cpu_clk_75M);
    chk1("drain_req_not_reissued", dbus_req, 1'b1);
    dbus_ack = 1'b1; dbus_rdata = 32'h5566_7788;
    @(negedge cpu_clk_75M);
    dbus_ack = 1'b0;
    chk1("drain_req_dropped", dbus_req, 1'b0);
    chk32("drain_load_kept", load_data, last_ld);
    chk1("drain_idle_stall", stallreq_mem, 1'b1);
    @(negedge cpu_clk_75M);
    chk1("post_drain_req", dbus_req, 1'b1);
    chk32("post_drain_addr", dbus_addr, 32'h0000_0400);
    chk32("post_drain_be", 32'(dbus_be), 32'h2);
    dbus_ack = 1'b1; dbus_rdata = 32'h0000_AB00;
    @(negedge cpu_clk_75M);
    dbus_ack = 1'b0;
    last_ld = 32'h0000_00AB;
    chk32("post_drain_load", load_data, last_ld);
    mem_aluop = OP_NOP;
    @(negedge cpu_clk_75M);

    // Asynchronous reset mid-transaction; stray ack afterwards is ignored.
    mem_aluop = OP_LW; mem_mem_addr = 32'h0000_0500;
    @(negedge cpu_clk_75M);
    chk1("rst_mid_req_up", dbus_req, 1'b1);
    cpu_rst_n = 1'b0; mem_aluop = OP_NOP;
    #1;
    chk1("rst_mid_req", dbus_req, 1'b0);
    chk32("rst_mid_addr", dbus_addr, 32'h0);
    chk32("rst_mid_load", load_data, 32'h0);
    chk1("rst_mid_stall", stallreq_mem, 1'b0);
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge cpu_clk_75M);
    dbus_ack = 1'b0;
    chk1("stray_ack_req", dbus_req, 1'b0);
    chk32("stray_ack_load", load_data, 32'h0);
    @(negedge cpu_clk_75M);
    chk1("stray_ack_idle", dbus_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
